pzcorebus_csrbus_responder_id_tracker: RTL and testbench

PZCOREBUS_CSRBUS_RESPONDER_ID_TRACKER -- requirements
Module: pzcorebus_csrbus_responder_id_tracker

---
 rtl/pzcorebus_csrbus_responder_id_tracker.sv | 153 +++++++++++++++
 tb/tb_pzcorebus_csrbus_responder_id_tracker.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_csrbus_responder_id_tracker.sv
// pzcorebus_csrbus_responder_id_tracker
//   Purpose : tracks outstanding csrbus commands in a ring of ENTRIES slots, issues them
//             to an in-order backend and returns ID-tagged responses in command order.
//   Latency : command -> backend request is combinational; ack in cycle N -> o_sresp_valid
//             in cycle N+1 when the acked slot is at the read pointer.
//   Backpressure : o_scmd_accept drops when the alloc slot is not FREE or i_req_ready is low;
//             a held response (i_mresp_accept=0) stalls slot release and eventually allocation.
// Ports:
//   i_clk / i_rst_n               clock, asynchronous active-low reset
//   i_mcmd_valid/o_scmd_accept    command handshake; i_mcmd 00 rd, 01 np wr, 10 posted wr, 11 rd
//   i_mid/i_maddr/i_mdata         command id, address, write data
//   o_sresp_valid/i_mresp_accept  response handshake with o_sid/o_serror/o_sdata
//   o_req_*/i_req_ready           backend request (combinational pass-through)
//   i_ack_*                       backend completion, one per request, in order, no backpressure
//   o_error_count                 present only when PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
//                                 is defined: saturating count of accepted error acks
`timescale 1ns/1ps
module pzcorebus_csrbus_responder_id_tracker #(
  parameter int ID_WIDTH      = 8,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int ENTRIES       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_mcmd_valid,
  output logic                     o_scmd_accept,
  input  logic [1:0]               i_mcmd,
  input  logic [ID_WIDTH-1:0]      i_mid,
  input  logic [ADDRESS_WIDTH-1:0] i_maddr,
  input  logic [DATA_WIDTH-1:0]    i_mdata,
  output logic                     o_sresp_valid,
  input  logic                     i_mresp_accept,
  output logic [ID_WIDTH-1:0]      o_sid,
  output logic                     o_serror,
  output logic [DATA_WIDTH-1:0]    o_sdata,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic                     o_req_write,
  output logic [ADDRESS_WIDTH-1:0] o_req_addr,
  output logic [DATA_WIDTH-1:0]    o_req_wdata,
  input  logic                     i_ack_valid,
  input  logic                     i_ack_error,
  input  logic [DATA_WIDTH-1:0]    i_ack_rdata
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
  ,
  output logic [15:0]              o_error_count
`endif
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_t;

  slot_state_t             slot_state  [ENTRIES];
  logic                    slot_posted [ENTRIES];
  logic                    slot_write  [ENTRIES];
  logic [ID_WIDTH-1:0]     slot_id     [ENTRIES];
  logic                    slot_serror [ENTRIES];
  logic [DATA_WIDTH-1:0]   slot_sdata  [ENTRIES];

  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] read_ptr;

  logic alloc_free;
  logic cmd_hs;
  logic cmd_write;
  logic ack_take;
  logic head_filled;
  logic rsp_release;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(ENTRIES - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Accept depends only on registered slot state, so a slot released this
  // cycle becomes allocatable on the next one. Gating with i_rst_n keeps the
  // handshake outputs low for the whole reset window.
  assign alloc_free    = (slot_state[alloc_ptr] == SLOT_FREE);
  assign o_scmd_accept = i_rst_n && i_req_ready && alloc_free;
  assign o_req_valid   = i_rst_n && i_mcmd_valid && alloc_free;
  assign cmd_write     = (i_mcmd == 2'b01) || (i_mcmd == 2'b10);
  assign o_req_write   = cmd_write;
  assign o_req_addr    = i_maddr;
  assign o_req_wdata   = i_mdata;
  assign cmd_hs        = i_mcmd_valid && o_scmd_accept;

  // Acks arriving with nothing outstanding are dropped.
  assign ack_take = i_ack_valid && (slot_state[fill_ptr] == SLOT_PENDING);

  // Posted entries retire silently as soon as they are filled at the head.
  assign head_filled   = (slot_state[read_ptr] == SLOT_FILLED);
  assign o_sresp_valid = head_filled && !slot_posted[read_ptr];
  assign rsp_release   = head_filled && (slot_posted[read_ptr] || i_mresp_accept);
  assign o_sid         = slot_id[read_ptr];
  assign o_serror      = slot_serror[read_ptr];
  assign o_sdata       = slot_sdata[read_ptr];

  // alloc, fill and release each require a different slot state, so even
  // when pointers coincide the three updates never touch the same slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        slot_state[i]  <= SLOT_FREE;
        slot_posted[i] <= 1'b0;
        slot_write[i]  <= 1'b0;
        slot_id[i]     <= '0;
        slot_serror[i] <= 1'b0;
        slot_sdata[i]  <= '0;
      end
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
    end else begin
      if (cmd_hs) begin
        slot_state[alloc_ptr]  <= SLOT_PENDING;
        slot_posted[alloc_ptr] <= (i_mcmd == 2'b10);
        slot_write[alloc_ptr]  <= cmd_write;
        slot_id[alloc_ptr]     <= i_mid;
        alloc_ptr              <= ptr_next(alloc_ptr);
      end
      if (ack_take) begin
        slot_state[fill_ptr]  <= SLOT_FILLED;
        slot_serror[fill_ptr] <= i_ack_error;
        slot_sdata[fill_ptr]  <= slot_write[fill_ptr] ? '0 : i_ack_rdata;
        fill_ptr              <= ptr_next(fill_ptr);
      end
      if (rsp_release) begin
        slot_state[read_ptr] <= SLOT_FREE;
        read_ptr             <= ptr_next(read_ptr);
      end
    end
  end

`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_error_count <= '0;
    end else if (ack_take && i_ack_error && (o_error_count != 16'hFFFF)) begin
      o_error_count <= o_error_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pzcorebus_csrbus_responder_id_tracker.sv
`timescale 1ns/1ps
module tb_pzcorebus_csrbus_responder_id_tracker;

  localparam int ENTRIES = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_mcmd_valid;
  logic        o_scmd_accept;
  logic [1:0]  i_mcmd;
  logic [7:0]  i_mid;
  logic [15:0] i_maddr;
  logic [31:0] i_mdata;
  logic        o_sresp_valid;
  logic        i_mresp_accept;
  logic [7:0]  o_sid;
  logic        o_serror;
  logic [31:0] o_sdata;
  logic        o_req_valid;
  logic        i_req_ready;
  logic        o_req_write;
  logic [15:0] o_req_addr;
  logic [31:0] o_req_wdata;
  logic        i_ack_valid;
  logic        i_ack_error;
  logic [31:0] i_ack_rdata;
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
  logic [15:0] o_error_count;
`endif

  pzcorebus_csrbus_responder_id_tracker #(
    .ID_WIDTH(8), .ADDRESS_WIDTH(16), .DATA_WIDTH(32), .ENTRIES(ENTRIES)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_mcmd_valid(i_mcmd_valid), .o_scmd_accept(o_scmd_accept), .i_mcmd(i_mcmd),
    .i_mid(i_mid), .i_maddr(i_maddr), .i_mdata(i_mdata),
    .o_sresp_valid(o_sresp_valid), .i_mresp_accept(i_mresp_accept),
    .o_sid(o_sid), .o_serror(o_serror), .o_sdata(o_sdata),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_write(o_req_write),
    .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
    .i_ack_valid(i_ack_valid), .i_ack_error(i_ack_error), .i_ack_rdata(i_ack_rdata)
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
    , .o_error_count(o_error_count)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    i_mcmd_valid = 1'b0; i_mcmd = 2'b00; i_mid = 8'h00; i_maddr = 16'h0; i_mdata = 32'h0;
    i_mresp_accept = 1'b0; i_req_ready = 1'b0;
    i_ack_valid = 1'b0; i_ack_error = 1'b0; i_ack_rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reset with every input active: the handshake/response outputs must stay 0.
  task automatic do_reset();
    set_idle();
    i_mcmd_valid = 1'b1; i_req_ready = 1'b1; i_mresp_accept = 1'b1;
    i_ack_valid = 1'b1; i_ack_rdata = 32'hFFFF_FFFF;
    i_rst_n = 1'b0;
    #2;
    chk("rst_scmd_accept", 64'(o_scmd_accept), 64'd0);
    chk("rst_req_valid",   64'(o_req_valid),   64'd0);
    chk("rst_sresp_valid", 64'(o_sresp_valid), 64'd0);
    chk("rst_sid",         64'(o_sid),         64'd0);
    chk("rst_serror",      64'(o_serror),      64'd0);
    chk("rst_sdata",       64'(o_sdata),       64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    set_idle();
    i_rst_n = 1'b1;
  endtask

  typedef struct {
    logic        mv;   logic [1:0] cmd; logic [7:0] mid; logic rdy;
    logic        av;   logic aerr;      logic [31:0] ard; logic macc;
    logic        e_acc; logic e_rv; logic e_rw; logic e_sv;
    logic [7:0]  e_sid; logic e_serr; logic [31:0] e_sdata;
  } vec_t;

  vec_t vt [15];

  // Behavioural reference: ordered list of outstanding commands.
  typedef struct {
    logic [7:0]  id;
    bit          posted;
    bit          wr;
    bit          acked;
    bit          err;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];

  logic hs;
  int   sent, acked, rcv;
  bit   e_acc, e_rv, e_rw, e_sv, rel;
  int   tgt;
  ent_t ne;
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
  int   model_errs;
`endif

  initial begin
    set_idle();
    i_rst_n = 1'b1;
    #3;
    do_reset();

    // ---------------- table-driven directed sequence ----------------
    //          mv    cmd    mid    rdy   av    aerr  ard            macc  acc   rv    rw    sv    sid    serr  sdata
    vt[0]  = '{1'b1,2'b00,8'h12,1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[1]  = '{1'b0,2'b00,8'h00,1'b1,1'b1,1'b0,32'hCAFE0001, 1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[2]  = '{1'b0,2'b00,8'h00,1'b1,1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,1'b1,8'h12,1'b0,32'hCAFE0001};
    vt[3]  = '{1'b1,2'b10,8'h01,1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,32'h0};
    vt[4]  = '{1'b1,2'b00,8'h02,1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b1,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[5]  = '{1'b0,2'b00,8'h00,1'b1,1'b1,1'b0,32'h11111111, 1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[6]  = '{1'b0,2'b00,8'h00,1'b1,1'b1,1'b0,32'h22222222, 1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[7]  = '{1'b0,2'b00,8'h00,1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b0,1'b1,8'h02,1'b0,32'h22222222};
    vt[8]  = '{1'b0,2'b00,8'h00,1'b1,1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,1'b1,8'h02,1'b0,32'h22222222};
    vt[9]  = '{1'b1,2'b11,8'h05,1'b0,1'b0,1'b0,32'h0,        1'b0, 1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[10] = '{1'b1,2'b01,8'h06,1'b1,1'b0,1'b0,32'h0,        1'b0, 1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,32'h0};
    vt[11] = '{1'b0,2'b00,8'h00,1'b1,1'b1,1'b1,32'hDEADBEEF, 1'b0, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[12] = '{1'b0,2'b00,8'h00,1'b1,1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,1'b1,8'h06,1'b1,32'h0};
    vt[13] = '{1'b0,2'b00,8'h00,1'b0,1'b1,1'b0,32'h12345678, 1'b0, 1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,32'h0};
    vt[14] = '{1'b0,2'b00,8'h00,1'b1,1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,1'b0,8'h00,1'b0,32'h0};

    for (int i = 0; i < 15; i++) begin
      i_mcmd_valid = vt[i].mv; i_mcmd = vt[i].cmd; i_mid = vt[i].mid; i_req_ready = vt[i].rdy;
      i_ack_valid = vt[i].av; i_ack_error = vt[i].aerr; i_ack_rdata = vt[i].ard;
      i_mresp_accept = vt[i].macc;
      i_maddr = 16'(16'h0040 + i); i_mdata = 32'hA5A50000 + 32'(i);
      @(negedge i_clk);
      chk($sformatf("vec%0d_scmd_accept", i), 64'(o_scmd_accept), 64'(vt[i].e_acc));
      chk($sformatf("vec%0d_req_valid", i),   64'(o_req_valid),   64'(vt[i].e_rv));
      chk($sformatf("vec%0d_req_write", i),   64'(o_req_write),   64'(vt[i].e_rw));
      chk($sformatf("vec%0d_req_addr", i),    64'(o_req_addr),    64'(16'h0040 + i));
      chk($sformatf("vec%0d_sresp_valid", i), 64'(o_sresp_valid), 64'(vt[i].e_sv));
      if (vt[i].e_sv) begin
        chk($sformatf("vec%0d_sid", i),    64'(o_sid),    64'(vt[i].e_sid));
        chk($sformatf("vec%0d_serror", i), 64'(o_serror), 64'(vt[i].e_serr));
        chk($sformatf("vec%0d_sdata", i),  64'(o_sdata),  64'(vt[i].e_sdata));
      end
      tick();
    end
    set_idle();

    // ---------------- full: 4 reads held, 5th refused ----------------
    do_reset();
    i_req_ready = 1'b1; i_mcmd = 2'b00;
    for (int i = 0; i < ENTRIES; i++) begin
      i_mcmd_valid = 1'b1; i_mid = 8'(8'hA0 + i);
      @(negedge i_clk);
      chk($sformatf("full_accept%0d", i), 64'(o_scmd_accept), 64'd1);
      tick();
    end
    i_mcmd_valid = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      i_ack_valid = 1'b1; i_ack_rdata = 32'h1000 + 32'(i);
      tick();
    end
    i_ack_valid = 1'b0;
    i_mcmd_valid = 1'b1; i_mid = 8'hA4;
    @(negedge i_clk);
    chk("full_accept_blocked", 64'(o_scmd_accept), 64'd0);
    chk("full_head_valid", 64'(o_sresp_valid), 64'd1);
    chk("full_head_sid", 64'(o_sid), 64'hA0);
    tick();
    i_mresp_accept = 1'b1;
    @(negedge i_clk);
    chk("full_accept_same_cycle", 64'(o_scmd_accept), 64'd0);
    chk("full_head_sdata", 64'(o_sdata), 64'h1000);
    tick();
    i_mresp_accept = 1'b0;
    @(negedge i_clk);
    chk("full_accept_after_free", 64'(o_scmd_accept), 64'd1);
    chk("full_next_sid", 64'(o_sid), 64'hA1);
    tick();
    set_idle();

    // ---------------- wrap: 10 non-posted writes, error on 7th ----------------
    do_reset();
    sent = 0; acked = 0; rcv = 0;
    i_req_ready = 1'b1; i_mresp_accept = 1'b1; i_mcmd = 2'b01;
    for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
      i_mcmd_valid = (sent < 10); i_mid = 8'(sent); i_mdata = $urandom;
      i_ack_valid = (acked < sent); i_ack_error = (acked == 6); i_ack_rdata = $urandom;
      @(negedge i_clk);
      hs = i_mcmd_valid && o_scmd_accept;
      if (o_sresp_valid) begin
        chk($sformatf("wrap_sid%0d", rcv),    64'(o_sid),    64'(rcv));
        chk($sformatf("wrap_serror%0d", rcv), 64'(o_serror), 64'(rcv == 6));
        chk($sformatf("wrap_sdata%0d", rcv),  64'(o_sdata),  64'd0);
        rcv++;
      end
      tick();
      if (hs) sent++;
      if (i_ack_valid) acked++;
    end
    chk("wrap_response_count", 64'(rcv), 64'd10);
    set_idle();

    // ---------------- reset mid-operation ----------------
    do_reset();
    i_req_ready = 1'b1; i_mcmd = 2'b00;
    for (int i = 0; i < 3; i++) begin
      i_mcmd_valid = 1'b1; i_mid = 8'(8'h30 + i);
      tick();
    end
    i_ack_valid = 1'b1; i_ack_rdata = 32'h5555AAAA; i_mresp_accept = 1'b1;
    tick();
    i_ack_valid = 1'b0; i_mresp_accept = 1'b0;
    // head is now a filled read; pull reset mid-cycle with inputs active
    i_mcmd_valid = 1'b1; i_ack_valid = 1'b1;
    #1;
    chk("midrst_pre_valid", 64'(o_sresp_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_scmd_accept", 64'(o_scmd_accept), 64'd0);
    chk("midrst_req_valid",   64'(o_req_valid),   64'd0);
    chk("midrst_sresp_valid", 64'(o_sresp_valid), 64'd0);
    chk("midrst_sid",         64'(o_sid),         64'd0);
    chk("midrst_sdata",       64'(o_sdata),       64'd0);
    set_idle();
    tick();
    i_rst_n = 1'b1;
    i_req_ready = 1'b1; i_mcmd_valid = 1'b1; i_mcmd = 2'b00; i_mid = 8'h33;
    @(negedge i_clk);
    chk("postrst_accept", 64'(o_scmd_accept), 64'd1);
    tick();
    i_mcmd_valid = 1'b0; i_ack_valid = 1'b1; i_ack_rdata = 32'h0BADF00D;
    tick();
    i_ack_valid = 1'b0; i_mresp_accept = 1'b1;
    @(negedge i_clk);
    chk("postrst_valid", 64'(o_sresp_valid), 64'd1);
    chk("postrst_sid",   64'(o_sid),         64'h33);
    chk("postrst_sdata", 64'(o_sdata),       64'h0BADF00D);
    tick();
    set_idle();

    // ---------------- randomized against reference model ----------------
    do_reset();
    q.delete();
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
    model_errs = 0;
`endif
    for (int cyc = 0; cyc < 2000; cyc++) begin
      i_mcmd_valid   = ($urandom_range(0, 9) < 6);
      i_mcmd         = 2'($urandom_range(0, 3));
      i_mid          = 8'($urandom);
      i_maddr        = 16'($urandom);
      i_mdata        = $urandom;
      i_req_ready    = ($urandom_range(0, 3) != 0);
      i_ack_valid    = ($urandom_range(0, 1) == 1);
      i_ack_error    = ($urandom_range(0, 4) == 0);
      i_ack_rdata    = $urandom;
      i_mresp_accept = ($urandom_range(0, 9) < 6);
      @(negedge i_clk);
      e_acc = i_req_ready && (q.size() < ENTRIES);
      e_rv  = i_mcmd_valid && (q.size() < ENTRIES);
      e_rw  = (i_mcmd == 2'b01) || (i_mcmd == 2'b10);
      e_sv  = (q.size() > 0) && q[0].acked && !q[0].posted;
      chk("rnd_scmd_accept", 64'(o_scmd_accept), 64'(e_acc));
      chk("rnd_req_valid",   64'(o_req_valid),   64'(e_rv));
      chk("rnd_req_write",   64'(o_req_write),   64'(e_rw));
      chk("rnd_req_wdata",   64'(o_req_wdata),   64'(i_mdata));
      chk("rnd_sresp_valid", 64'(o_sresp_valid), 64'(e_sv));
      if (e_sv) begin
        chk("rnd_sid",    64'(o_sid),    64'(q[0].id));
        chk("rnd_serror", 64'(o_serror), 64'(q[0].err));
        chk("rnd_sdata",  64'(o_sdata),  64'(q[0].data));
      end
      // state change at the coming edge, all decided from current state
      rel = (q.size() > 0) && q[0].acked && (q[0].posted || i_mresp_accept);
      tgt = -1;
      for (int k = 0; k < q.size(); k++) begin
        if (!q[k].acked) begin tgt = k; break; end
      end
      if (i_ack_valid && tgt >= 0) begin
        q[tgt].acked = 1'b1;
        q[tgt].err   = i_ack_error;
        q[tgt].data  = q[tgt].wr ? 32'h0 : i_ack_rdata;
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
        if (i_ack_error && model_errs < 65535) model_errs++;
`endif
      end
      if (rel) void'(q.pop_front());
      if (i_mcmd_valid && e_acc) begin
        ne.id = i_mid; ne.posted = (i_mcmd == 2'b10); ne.wr = e_rw;
        ne.acked = 1'b0; ne.err = 1'b0; ne.data = 32'h0;
        q.push_back(ne);
      end
      tick();
    end
`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
    chk("rnd_error_count", 64'(o_error_count), 64'(model_errs));
`endif
    set_idle();

`ifdef PZCOREBUS_CSRBUS_RESPONDER_ERROR_COUNTER_EN
    // ---------------- error counter: small count, then saturation ----------------
    do_reset();
    chk("cnt_reset", 64'(o_error_count), 64'd0);
    i_req_ready = 1'b1; i_mcmd = 2'b10;
    for (int i = 0; i < 3; i++) begin
      i_mcmd_valid = 1'b1; tick();
      i_mcmd_valid = 1'b0; i_ack_valid = 1'b1; i_ack_error = 1'b1; tick();
      i_ack_valid = 1'b0; i_ack_error = 1'b0;
    end
    tick();
    chk("cnt_three", 64'(o_error_count), 64'd3);
    i_mcmd_valid = 1'b1; i_ack_valid = 1'b1; i_ack_error = 1'b1;
    repeat (65600) @(posedge i_clk);
    #1;
    chk("cnt_saturated", 64'(o_error_count), 64'hFFFF);
    set_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
